// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: receives command frames, answers R1, and streams
// read/write data blocks between the SPI master and an external byte store.
`timescale 1ns/1ps
module sd_spi_responder #(
    parameter int unsigned BLOCK_BYTES = 512,
    parameter logic [7:0]  IDLE_R1     = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        sclk,
    input  logic        mosi,
    output logic        miso,
    output logic [31:0] blk_addr,
    output logic [8:0]  rd_addr,
    input  logic [7:0]  rd_data,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        card_ready
);

    localparam logic [8:0] LAST_ADDR = 9'(BLOCK_BYTES - 1);
    // Bit order {cs, sclk, mosi}; reset to the idle bus (deselected, clock low).
    localparam logic [2:0] SYNC_IDLE = 3'b101;

    typedef enum logic [3:0] {
        CMD_RX, NCR, R1, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC,
        WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY
    } state_t;

    state_t      state_q, state_d;

    logic [2:0]  meta_q, sync_q;
    logic        sclk_prev_q;
    logic        cs_s, sclk_s, mosi_s;
    logic        sclk_rise, sclk_fall, byte_done;

    logic [2:0]  bit_cnt_q;
    logic [6:0]  rx_sr_q;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_sr_q;
    logic [7:0]  tx_byte;

    logic [2:0]  frm_cnt_q;
    logic [5:0]  cmd_idx_q;
    logic [31:0] arg_q;
    logic [7:0]  r1_q, r1_d;
    logic        op_rd_q, op_wr_q;
    logic        acmd_q, acmd_d;
    logic        card_ready_q, ready_d;
    logic        is_rd, is_wr;
    logic [31:0] blk_addr_q;

    logic [8:0]  rd_addr_q;
    logic        wr_en_q;
    logic [7:0]  wr_data_q;
    logic        crc_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q      <= SYNC_IDLE;
            sync_q      <= SYNC_IDLE;
            sclk_prev_q <= 1'b0;
        end else begin
            meta_q      <= {cs, sclk, mosi};
            sync_q      <= meta_q;
            sclk_prev_q <= sync_q[1];
        end
    end

    assign cs_s      = sync_q[2];
    assign sclk_s    = sync_q[1];
    assign mosi_s    = sync_q[0];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign rx_byte   = {rx_sr_q, mosi_s};
    assign byte_done = ~cs_s & sclk_rise & (bit_cnt_q == 3'd7);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q <= 3'd0;
            rx_sr_q   <= 7'd0;
        end else if (cs_s) begin
            bit_cnt_q <= 3'd0;
        end else if (sclk_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            rx_sr_q   <= rx_byte[6:0];
        end
    end

    // A fresh byte is loaded on the fall that follows the last rise of the
    // previous byte, so its MSB is on the wire before the next byte's first rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sr_q <= 8'hFF;
        end else if (cs_s) begin
            tx_sr_q <= 8'hFF;
        end else if (sclk_fall) begin
            tx_sr_q <= (bit_cnt_q == 3'd0) ? tx_byte : {tx_sr_q[6:0], 1'b1};
        end
    end

    assign miso = tx_sr_q[7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= CMD_RX;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_s) begin
            state_d = CMD_RX;
        end else if (byte_done) begin
            case (state_q)
                CMD_RX:   if (frm_cnt_q == 3'd5) state_d = NCR;
                NCR:      state_d = R1;
                R1: begin
                    if (op_rd_q)      state_d = RD_GAP;
                    else if (op_wr_q) state_d = WR_TOKEN;
                    else              state_d = CMD_RX;
                end
                RD_GAP:   state_d = RD_TOKEN;
                RD_TOKEN: state_d = RD_DATA;
                RD_DATA:  if (rd_addr_q == LAST_ADDR) state_d = RD_CRC;
                RD_CRC:   if (crc_cnt_q) state_d = CMD_RX;
                WR_TOKEN: if (rx_byte == 8'hFE) state_d = WR_DATA;
                WR_DATA:  if (rd_addr_q == LAST_ADDR) state_d = WR_CRC;
                WR_CRC:   if (crc_cnt_q) state_d = WR_RESP;
                WR_RESP:  state_d = WR_BUSY;
                WR_BUSY:  state_d = CMD_RX;
                default:  state_d = CMD_RX;
            endcase
        end
    end

    always_comb begin
        tx_byte = 8'hFF;
        case (state_q)
            R1:       tx_byte = r1_q;
            RD_TOKEN: tx_byte = 8'hFE;
            RD_DATA:  tx_byte = rd_data;
            WR_RESP:  tx_byte = 8'h05;
            WR_BUSY:  tx_byte = 8'h00;
            default:  tx_byte = 8'hFF;
        endcase
    end

    // Command decode, evaluated against the frame held once the CRC byte arrives.
    always_comb begin
        r1_d    = 8'h04 | {7'b0, ~card_ready_q};
        ready_d = card_ready_q;
        acmd_d  = 1'b0;
        is_rd   = 1'b0;
        is_wr   = 1'b0;
        case (cmd_idx_q)
            6'd0: begin
                r1_d    = IDLE_R1;
                ready_d = 1'b0;
            end
            6'd55: begin
                r1_d   = {7'b0, ~card_ready_q};
                acmd_d = 1'b1;
            end
            6'd41: begin
                if (acmd_q) begin
                    r1_d    = 8'h00;
                    ready_d = 1'b1;
                end
            end
            6'd17: begin
                r1_d  = card_ready_q ? 8'h00 : 8'h05;
                is_rd = card_ready_q;
            end
            6'd24: begin
                r1_d  = card_ready_q ? 8'h00 : 8'h05;
                is_wr = card_ready_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm_cnt_q    <= 3'd0;
            cmd_idx_q    <= 6'd0;
            arg_q        <= 32'd0;
            r1_q         <= 8'hFF;
            op_rd_q      <= 1'b0;
            op_wr_q      <= 1'b0;
            acmd_q       <= 1'b0;
            card_ready_q <= 1'b0;
            blk_addr_q   <= 32'd0;
        end else if (cs_s) begin
            frm_cnt_q <= 3'd0;
        end else if (byte_done && state_q == CMD_RX) begin
            if (frm_cnt_q == 3'd0) begin
                if (rx_byte[7:6] == 2'b01) begin
                    cmd_idx_q <= rx_byte[5:0];
                    frm_cnt_q <= 3'd1;
                end
            end else if (frm_cnt_q < 3'd5) begin
                arg_q     <= {arg_q[23:0], rx_byte};
                frm_cnt_q <= frm_cnt_q + 3'd1;
            end else begin
                frm_cnt_q    <= 3'd0;
                r1_q         <= r1_d;
                op_rd_q      <= is_rd;
                op_wr_q      <= is_wr;
                acmd_q       <= acmd_d;
                card_ready_q <= ready_d;
                if (is_rd || is_wr) blk_addr_q <= arg_q;
            end
        end
    end

    // In a write the address steps after the strobe so wr_en sees the byte index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_q <= 9'd0;
            wr_en_q   <= 1'b0;
            wr_data_q <= 8'd0;
            crc_cnt_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (cs_s) begin
                rd_addr_q <= 9'd0;
                crc_cnt_q <= 1'b0;
            end else begin
                if (byte_done && state_q == WR_DATA) begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= rx_byte;
                end
                if ((byte_done && state_q == RD_DATA) || wr_en_q) begin
                    rd_addr_q <= (rd_addr_q == LAST_ADDR) ? 9'd0 : rd_addr_q + 9'd1;
                end
                if (byte_done && (state_q == RD_CRC || state_q == WR_CRC)) begin
                    crc_cnt_q <= ~crc_cnt_q;
                end
            end
        end
    end

    assign blk_addr   = blk_addr_q;
    assign rd_addr    = rd_addr_q;
    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign card_ready = card_ready_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Directed bench for sd_spi_responder: an SPI master drives command frames and
// data blocks, a byte-store model feeds reads, and a monitor logs write strobes.
`timescale 1ns/1ps
module tb_sd_spi_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic [31:0] blk_addr;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        card_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:511];
    int         wr_cnt = 0;
    int         wr_base = 0;
    int         wr_err = 0;
    int         wr_mode = 0;
    int         mon_idx;
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    sd_spi_responder #(.BLOCK_BYTES(512), .IDLE_R1(8'h01)) dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .sclk       (sclk),
        .mosi       (mosi),
        .miso       (miso),
        .blk_addr   (blk_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .card_ready (card_ready)
    );

    always @(posedge clk) rd_data <= mem[rd_addr];

    // Write monitor: every strobe must carry the next byte index and pattern byte.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            mon_idx = wr_cnt - wr_base;
            mon_exp = (wr_mode != 0) ? 8'(mon_idx + 3) : 8'hA5;
            if (rd_addr !== 9'(mon_idx) || wr_data !== mon_exp) wr_err++;
            wr_cnt++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'hFF;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (4) @(negedge clk);
            rx[7-i] = miso;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        mosi = 1'b1;
        cs   = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                            output logic [7:0] ncr, output logic [7:0] r1);
        logic [7:0] fr [6];
        logic [7:0] dummy;
        fr[0] = {2'b01, idx};
        fr[1] = arg[31:24];
        fr[2] = arg[23:16];
        fr[3] = arg[15:8];
        fr[4] = arg[7:0];
        fr[5] = crc;
        for (int k = 0; k < 6; k++) spi_xfer(fr[k], 8, dummy);
        spi_xfer(8'hFF, 8, ncr);
        spi_xfer(8'hFF, 8, r1);
        $display("CMD%0d arg=%08h -> ncr=%02h r1=%02h card_ready=%0b", idx, arg, ncr, r1, card_ready);
    endtask

    logic [7:0] ncr, r1, rx;
    int         rd_err;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = i[7:0];
        rst = 1'b0; cs = 1'b1; sclk = 1'b0; mosi = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'h1);
        check("rst_blk_addr", blk_addr, 32'h0);
        check("rst_rd_addr", 32'(rd_addr), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h0);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_card_ready", 32'(card_ready), 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // CMD0 -> NCR 0xFF, R1 idle
        cs_low();
        send_cmd(6'd0, 32'h0, 8'h95, ncr, r1);
        check("cmd0_ncr", 32'(ncr), 32'hFF);
        check("cmd0_r1", 32'(r1), 32'h01);
        check("cmd0_ready", 32'(card_ready), 32'h0);
        cs_high();

        // CMD17 before init: illegal-state R1, no token follows
        cs_low();
        send_cmd(6'd17, 32'h200, 8'hFF, ncr, r1);
        check("rd_noinit_r1", 32'(r1), 32'h05);
        spi_xfer(8'hFF, 8, rx);
        check("rd_noinit_gap", 32'(rx), 32'hFF);
        spi_xfer(8'hFF, 8, rx);
        check("rd_noinit_notoken", 32'(rx), 32'hFF);
        cs_high();

        // ACMD41 initialisation
        cs_low();
        send_cmd(6'd55, 32'h0, 8'hFF, ncr, r1);
        check("cmd55_r1_idle", 32'(r1), 32'h01);
        send_cmd(6'd41, 32'h0, 8'hFF, ncr, r1);
        check("acmd41_r1", 32'(r1), 32'h00);
        check("acmd41_ready", 32'(card_ready), 32'h1);

        // Other command, and ACMD flag lasting one frame only
        send_cmd(6'd8, 32'h1AA, 8'h87, ncr, r1);
        check("cmd8_r1", 32'(r1), 32'h04);
        send_cmd(6'd55, 32'h0, 8'hFF, ncr, r1);
        check("cmd55_r1_ready", 32'(r1), 32'h00);
        send_cmd(6'd8, 32'h1AA, 8'h87, ncr, r1);
        send_cmd(6'd41, 32'h0, 8'hFF, ncr, r1);
        check("cmd41_noacmd_r1", 32'(r1), 32'h04);
        cs_high();

        // Full block read
        cs_low();
        send_cmd(6'd17, 32'h200, 8'hFF, ncr, r1);
        check("rd_ncr", 32'(ncr), 32'hFF);
        check("rd_r1", 32'(r1), 32'h00);
        check("rd_blk_addr", blk_addr, 32'h200);
        spi_xfer(8'hFF, 8, rx);
        check("rd_gap", 32'(rx), 32'hFF);
        spi_xfer(8'hFF, 8, rx);
        check("rd_token", 32'(rx), 32'hFE);
        rd_err = 0;
        for (int i = 0; i < 512; i++) begin
            spi_xfer(8'hFF, 8, rx);
            if (i == 0)   check("rd_first", 32'(rx), 32'h00);
            if (i == 511) check("rd_last", 32'(rx), 32'hFF);
            if (rx !== 8'(i)) rd_err++;
        end
        check("rd_data_errors", 32'(rd_err), 32'h0);
        spi_xfer(8'hFF, 8, rx);
        check("rd_crc0", 32'(rx), 32'hFF);
        spi_xfer(8'hFF, 8, rx);
        check("rd_crc1", 32'(rx), 32'hFF);
        check("rd_addr_wrap", 32'(rd_addr), 32'h0);
        $display("READ blk=%08h bytes=512 data_err=%0d", blk_addr, rd_err);
        cs_high();

        // Full block write
        cs_low();
        send_cmd(6'd24, 32'h400, 8'hFF, ncr, r1);
        check("wr_r1", 32'(r1), 32'h00);
        check("wr_blk_addr", blk_addr, 32'h400);
        wr_base = wr_cnt; wr_mode = 0;
        spi_xfer(8'hFF, 8, rx);
        spi_xfer(8'hFE, 8, rx);
        for (int i = 0; i < 512; i++) spi_xfer(8'hA5, 8, rx);
        spi_xfer(8'h12, 8, rx);
        spi_xfer(8'h34, 8, rx);
        spi_xfer(8'hFF, 8, rx);
        check("wr_resp", 32'(rx), 32'h05);
        spi_xfer(8'hFF, 8, rx);
        check("wr_busy", 32'(rx), 32'h00);
        spi_xfer(8'hFF, 8, rx);
        check("wr_idle", 32'(rx), 32'hFF);
        check("wr_pulses", 32'(wr_cnt - wr_base), 32'd512);
        check("wr_strobe_errors", 32'(wr_err), 32'h0);
        check("wr_addr_wrap", 32'(rd_addr), 32'h0);
        $display("WRITE blk=%08h pulses=%0d strobe_err=%0d", blk_addr, wr_cnt - wr_base, wr_err);
        cs_high();

        // Write aborted by cs after 100 bytes plus a partial byte
        cs_low();
        send_cmd(6'd24, 32'h600, 8'hFF, ncr, r1);
        check("abort_r1", 32'(r1), 32'h00);
        wr_base = wr_cnt; wr_mode = 1;
        spi_xfer(8'hFE, 8, rx);
        for (int i = 0; i < 100; i++) spi_xfer(8'(i + 3), 8, rx);
        spi_xfer(8'h55, 4, rx);
        cs_high();
        check("abort_pulses", 32'(wr_cnt - wr_base), 32'd100);
        cs_low();
        send_cmd(6'd0, 32'h0, 8'h95, ncr, r1);
        check("abort_cmd0_ncr", 32'(ncr), 32'hFF);
        check("abort_cmd0_r1", 32'(r1), 32'h01);
        check("abort_no_more_wr", 32'(wr_cnt - wr_base), 32'd100);
        check("abort_strobe_errors", 32'(wr_err), 32'h0);
        check("abort_ready_cleared", 32'(card_ready), 32'h0);
        $display("ABORT pulses=%0d strobe_err=%0d", wr_cnt - wr_base, wr_err);
        cs_high();

        // Asynchronous reset in the middle of a read
        cs_low();
        send_cmd(6'd55, 32'h0, 8'hFF, ncr, r1);
        send_cmd(6'd41, 32'h0, 8'hFF, ncr, r1);
        send_cmd(6'd17, 32'h800, 8'hFF, ncr, r1);
        check("rst_rd_r1", 32'(r1), 32'h00);
        check("rst_rd_blk_addr", blk_addr, 32'h800);
        spi_xfer(8'hFF, 8, rx);
        spi_xfer(8'hFF, 8, rx);
        for (int i = 0; i < 50; i++) spi_xfer(8'hFF, 8, rx);
        check("rst_rd_byte49", 32'(rx), 32'h31);
        spi_xfer(8'hFF, 3, rx);
        rst = 1'b0;
        #1;
        check("midrst_miso", 32'(miso), 32'h1);
        check("midrst_blk_addr", blk_addr, 32'h0);
        check("midrst_rd_addr", 32'(rd_addr), 32'h0);
        check("midrst_wr_en", 32'(wr_en), 32'h0);
        check("midrst_wr_data", 32'(wr_data), 32'h0);
        check("midrst_card_ready", 32'(card_ready), 32'h0);
        $display("RESET mid-read asserted");
        cs = 1'b1; mosi = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        cs_low();
        send_cmd(6'd17, 32'h200, 8'hFF, ncr, r1);
        check("postrst_r1", 32'(r1), 32'h05);
        cs_high();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter: BLOCK_BYTES, 512, data bytes per read/write block.
REQ-002 Parameter: IDLE_R1, 8'h01, R1 returned for CMD0.
REQ-003 Port: clk  in  1  system clock; all logic synchronous to it.
REQ-004 Port: rst  in  1  reset, asynchronous, active-low.
REQ-005 Port: cs  in  1  SPI chip select from the SD-card master, active-low.
REQ-006 Port: sclk  in  1  SPI clock from the master, mode 0; period at least 8 clk.
REQ-007 Port: mosi  in  1  SPI data from the master.
REQ-008 Port: miso  out  1  SPI data to the master.
REQ-009 Port: blk_addr  out  32  argument of the last accepted CMD17/CMD24.
REQ-010 Port: rd_addr  out  9  byte index into the block store.
REQ-011 Port: rd_data  in  8  block-store byte, valid 1 clk after rd_addr.
REQ-012 Port: wr_en  out  1  1-clk strobe writing wr_data at rd_addr.
REQ-013 Port: wr_data  out  8  byte received in a CMD24 data phase.
REQ-014 Port: card_ready  out  1  high once initialisation (ACMD41) has completed.

Function
REQ-015 cs, sclk and mosi SHALL pass through 2-FF synchronisers; edges SHALL be detected on the synchronised sclk.
REQ-016 mosi SHALL be sampled on sclk rise, MSB first; miso SHALL change only on sclk fall, except that bit 7 of each transmitted byte SHALL be valid before the first rise of that byte.
REQ-017 While cs is high, miso SHALL be 1, the bit counter SHALL clear, and the FSM SHALL return to CMD_RX; cs rising mid-transfer SHALL abort silently with no further wr_en.
REQ-018 FSM states: CMD_RX, NCR, R1, RD_GAP, RD_TOKEN, RD_DATA, RD_CRC, WR_TOKEN, WR_DATA, WR_CRC, WR_RESP, WR_BUSY.
REQ-019 CMD_RX: received bytes with bits[7:6] != 2'b01 SHALL be ignored; a 01 byte SHALL start a 6-byte frame (index, 4 argument bytes MSB-first, CRC ignored).
REQ-020 After byte 6, the FSM SHALL send one 0xFF byte (NCR), then the R1 byte.
REQ-021 R1 values:
- CMD0: IDLE_R1; card_ready cleared.
- CMD55: 0x01 if not ready, else 0x00; arms the ACMD flag for the next frame only.
- CMD41 with ACMD flag set: 0x00; card_ready set.
- CMD17/CMD24 when ready: 0x00.
- CMD17/CMD24 when not ready: 0x05.
- Any other command: 0x04 | {7'b0, ~card_ready}.
REQ-022 On an accepted CMD17/CMD24, blk_addr SHALL load the argument in the cycle byte 6 completes.
REQ-023 Read path:
- After R1: one 0xFF (RD_GAP), then 0xFE (RD_TOKEN).
- Then BLOCK_BYTES bytes of rd_data with rd_addr = 0..BLOCK_BYTES-1.
- Then two 0xFF CRC bytes, then return to CMD_RX.
- rd_addr SHALL advance at least 2 clk before the sclk rise for that byte's bit 7.
REQ-024 Write path:
- After R1, WR_TOKEN SHALL ignore bytes until 0xFE.
- Each following byte: wr_data SHALL be that byte and wr_en SHALL pulse once, 1 clk after bit 0 is sampled, with rd_addr = byte index.
- After BLOCK_BYTES bytes: 2 CRC bytes ignored, then 0x05 (WR_RESP), then one 0x00 (WR_BUSY).
- Then 0xFF and return to CMD_RX.
REQ-025 rd_addr SHALL wrap to 0 at the end of each data phase; no access SHALL occur beyond BLOCK_BYTES-1.
REQ-026 In all non-transmitting states miso SHALL idle at 1.

Reset
REQ-027 While rst is low: miso=1, blk_addr=0, rd_addr=0, wr_en=0, wr_data=0, card_ready=0, ACMD flag=0, FSM=CMD_RX.
REQ-028 Reset SHALL take effect immediately, asynchronously, including mid-block; release SHALL be synchronous to clk.

Verification
REQ-029 Frame 40 00 00 00 00 95 -> 0xFF then 0x01; card_ready=0.
REQ-030 CMD55 then CMD41 (69 00 00 00 00 FF) -> R1 0x01 then 0x00; card_ready=1.
REQ-031 CMD17 before init -> R1 0x05, no FE token.
REQ-032 CMD17 when ready, arg 0x00000200, store byte i = i[7:0] -> blk_addr=0x200; FF, 00, FF, FE, bytes 00..FF twice, FF FF.
REQ-033 CMD24 when ready, FE + 512 bytes 0xA5 + 2 CRC -> 512 wr_en pulses with wr_data=0xA5, addresses 0..511; then 0x05, 0x00, 0xFF.
REQ-034 cs raised after 100 bytes of a CMD24 data phase, then a new CMD0 -> exactly 100 wr_en pulses, then 0xFF 0x01; repeated with rst asserted mid-read -> all outputs at reset values.
